// File: rtl/game_pkg.sv
// Shared definitions for the game round controller: state encodings and
// widths that both the controller and anything observing `step` rely on.
package game_pkg;

  localparam int STEP_W  = 4;
  localparam int ROUND_W = 8;

  // Encodings are visible on the step output, so they must stay fixed.
  typedef enum logic [STEP_W-1:0] {
    ST_IDLE  = 4'd0,
    ST_GEN   = 4'd1,
    ST_PICK  = 4'd2,
    ST_SHOW  = 4'd3,
    ST_TOUT  = 4'd4,
    ST_CHECK = 4'd7,
    ST_WIN   = 4'd8,
    ST_OVER  = 4'd9
  } game_state_e;

endpackage

// File: rtl/game_timer.sv
// PICK-phase watchdog: counts cycles while enabled and flags the last
// permitted cycle. A LIMIT of zero disables expiry entirely.
module game_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count;

  // Expiry fires on the final allowed cycle so the caller leaves after exactly LIMIT cycles.
  assign expired = (LIMIT != 0) && enable && (count == LAST);

  // Counter restarts whenever the caller is outside the timed phase and holds once expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Turn/round sequencer for a small multi-player game: rotates the active
// player, counts turns, keeps saturating per-player scores and bounds the
// time a player may spend picking.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int ROUNDS      = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SCORE_W     = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       rand_ready,
  input  logic                                       done,
  input  logic                                       select,
  input  logic                                       win,
  input  logic                                       miss,
  input  logic                                       finish,
  output logic [STEP_W-1:0]                          step,
  output logic [((PLAYERS > 1) ? $clog2(PLAYERS) : 1)-1:0] player,
  output logic [ROUND_W-1:0]                         round,
  output logic [PLAYERS*SCORE_W-1:0]                 score,
  output logic                                       timeout,
  output logic                                       game_over
);

  localparam int                 PW          = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam logic [PW-1:0]      PLAYER_LAST = PW'(PLAYERS - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST  = ROUND_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  game_state_e                state;
  game_state_e                state_nxt;
  logic [PW-1:0]              player_nxt;
  logic [ROUND_W-1:0]         round_nxt;
  logic [PLAYERS*SCORE_W-1:0] score_nxt;
  logic                       turn_end;
  logic                       score_bump;
  logic                       expired;

  game_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ST_PICK),
    .enable (state == ST_PICK),
    .expired(expired)
  );

  assign step = state;

  // Next-state, turn bookkeeping and score update for the coming edge.
  always_comb begin
    state_nxt  = state;
    player_nxt = player;
    round_nxt  = round;
    score_nxt  = score;
    turn_end   = 1'b0;
    score_bump = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_GEN;
          round_nxt  = '0;
          player_nxt = '0;
          score_nxt  = '0;
        end
      end
      ST_GEN: begin
        if (rand_ready) begin
          state_nxt = done ? ST_SHOW : ST_PICK;
        end
      end
      ST_SHOW: begin
        if (select) begin
          state_nxt = ST_PICK;
        end
      end
      ST_PICK: begin
        if (select && done) begin
          state_nxt = ST_CHECK;
        end else if (done) begin
          state_nxt = ST_GEN;
        end else if (expired) begin
          state_nxt = ST_TOUT;
        end
      end
      ST_TOUT: begin
        turn_end = 1'b1;
      end
      ST_CHECK: begin
        if (finish) begin
          state_nxt = ST_IDLE;
        end else if (win) begin
          state_nxt  = ST_WIN;
          score_bump = 1'b1;
        end else if (miss) begin
          turn_end = 1'b1;
        end
      end
      ST_WIN: begin
        if (finish) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          turn_end = 1'b1;
        end
      end
      ST_OVER: begin
        if (finish) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (turn_end) begin
      round_nxt  = round + ROUND_W'(1);
      player_nxt = (player == PLAYER_LAST) ? '0 : player + PW'(1);
      state_nxt  = (round_nxt == ROUND_LAST) ? ST_OVER : ST_GEN;
    end

    if (score_bump) begin
      for (int i = 0; i < PLAYERS; i++) begin
        if ((player == PW'(i)) && (score[i*SCORE_W +: SCORE_W] != SCORE_MAX)) begin
          score_nxt[i*SCORE_W +: SCORE_W] = score[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
        end
      end
    end
  end

  // All controller state; the status flags are decoded from the next state so they track step exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      player    <= '0;
      round     <= '0;
      score     <= '0;
      timeout   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      player    <= player_nxt;
      round     <= round_nxt;
      score     <= score_nxt;
      timeout   <= (state_nxt == ST_TOUT);
      game_over <= (state_nxt == ST_OVER);
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: two differently configured instances share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_game_round_ctrl;

  localparam int A_PLAYERS = 2, A_ROUNDS = 2, A_TMO = 4, A_SW = 4;
  localparam int B_PLAYERS = 1, B_ROUNDS = 7, B_TMO = 0, B_SW = 2;

  localparam int M_IDLE = 0, M_GEN = 1, M_PICK = 2, M_SHOW = 3, M_TOUT = 4;
  localparam int M_CHECK = 7, M_WIN = 8, M_OVER = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, rand_ready = 1'b0, done = 1'b0, select = 1'b0;
  logic win = 1'b0, miss = 1'b0, finish = 1'b0;

  logic [3:0] a_step, b_step;
  logic [0:0] a_player, b_player;
  logic [7:0] a_round, b_round;
  logic [A_PLAYERS*A_SW-1:0] a_score;
  logic [B_PLAYERS*B_SW-1:0] b_score;
  logic a_timeout, b_timeout, a_game_over, b_game_over;

  int n_compared = 0;
  int n_mismatched = 0;
  bit check_en = 1'b0;

  int cfg_players[2] = '{A_PLAYERS, B_PLAYERS};
  int cfg_rounds[2]  = '{A_ROUNDS, B_ROUNDS};
  int cfg_tmo[2]     = '{A_TMO, B_TMO};
  int cfg_sw[2]      = '{A_SW, B_SW};

  int m_st[2];
  int m_tmr[2];
  int m_rnd[2];
  int m_ply[2];
  int m_sc[2][4];

  always #5 clk = ~clk;

  game_round_ctrl #(
    .PLAYERS(A_PLAYERS), .ROUNDS(A_ROUNDS), .TIMEOUT_CYC(A_TMO), .SCORE_W(A_SW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .rand_ready(rand_ready), .done(done),
    .select(select), .win(win), .miss(miss), .finish(finish),
    .step(a_step), .player(a_player), .round(a_round), .score(a_score),
    .timeout(a_timeout), .game_over(a_game_over)
  );

  game_round_ctrl #(
    .PLAYERS(B_PLAYERS), .ROUNDS(B_ROUNDS), .TIMEOUT_CYC(B_TMO), .SCORE_W(B_SW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rand_ready(rand_ready), .done(done),
    .select(select), .win(win), .miss(miss), .finish(finish),
    .step(b_step), .player(b_player), .round(b_round), .score(b_score),
    .timeout(b_timeout), .game_over(b_game_over)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE;
      m_tmr[k] = 0;
      m_rnd[k] = 0;
      m_ply[k] = 0;
      for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
    end
  endtask

  // One game step of instance k under the current inputs, from the game rules.
  task automatic model_clock(input int k);
    int ns;
    bit turn_over;
    int top;
    ns = m_st[k];
    turn_over = 1'b0;
    top = (1 << cfg_sw[k]) - 1;
    case (m_st[k])
      M_IDLE: if (start) begin
        ns = M_GEN; m_rnd[k] = 0; m_ply[k] = 0;
        for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
      end
      M_GEN:  if (rand_ready) ns = done ? M_SHOW : M_PICK;
      M_SHOW: if (select) ns = M_PICK;
      M_PICK: begin
        if (select && done) ns = M_CHECK;
        else if (done) ns = M_GEN;
        else if (cfg_tmo[k] > 0 && m_tmr[k] == cfg_tmo[k] - 1) ns = M_TOUT;
      end
      M_TOUT: turn_over = 1'b1;
      M_CHECK: begin
        if (finish) ns = M_IDLE;
        else if (win) begin
          ns = M_WIN;
          if (m_sc[k][m_ply[k]] < top) m_sc[k][m_ply[k]]++;
        end else if (miss) turn_over = 1'b1;
      end
      M_WIN: begin
        if (finish) ns = M_IDLE;
        else if (start) turn_over = 1'b1;
      end
      M_OVER: if (finish) ns = M_IDLE;
      default: ns = M_IDLE;
    endcase
    if (turn_over) begin
      m_rnd[k]++;
      m_ply[k] = (m_ply[k] + 1) % cfg_players[k];
      ns = (m_rnd[k] == cfg_rounds[k]) ? M_OVER : M_GEN;
    end
    m_tmr[k] = (m_st[k] == M_PICK) ? m_tmr[k] + 1 : 0;
    m_st[k] = ns;
  endtask

  function automatic logic [31:0] exp_score(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < cfg_players[k]; i++) v = v | (32'(m_sc[k][i]) << (i * cfg_sw[k]));
    return v;
  endfunction

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst_n) begin
      model_clock(0);
      model_clock(1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      checkOutput("a_step", a_step, m_st[0]);
      checkOutput("a_player", a_player, m_ply[0]);
      checkOutput("a_round", a_round, m_rnd[0]);
      checkOutput("a_score", a_score, exp_score(0));
      checkOutput("a_timeout", a_timeout, m_st[0] == M_TOUT);
      checkOutput("a_game_over", a_game_over, m_st[0] == M_OVER);
      checkOutput("b_step", b_step, m_st[1]);
      checkOutput("b_player", b_player, m_ply[1]);
      checkOutput("b_round", b_round, m_rnd[1]);
      checkOutput("b_score", b_score, exp_score(1));
      checkOutput("b_timeout", b_timeout, m_st[1] == M_TOUT);
      checkOutput("b_game_over", b_game_over, m_st[1] == M_OVER);
    end
  end

  task automatic applyStimulus(input bit s, input bit rr, input bit dn, input bit sel,
                               input bit w, input bit ms, input bit fin);
    @(negedge clk);
    start = s; rand_ready = rr; done = dn; select = sel; win = w; miss = ms; finish = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    start = 0; rand_ready = 0; done = 0; select = 0; win = 0; miss = 0; finish = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sat_tbl[5];
    sat_tbl = '{1, 2, 3, 3, 3};

    do_reset();
    check_en = 1'b1;
    #1;
    checkOutput("rst_step", a_step, 0);
    checkOutput("rst_player", a_player, 0);
    checkOutput("rst_round", a_round, 0);
    checkOutput("rst_score", a_score, 0);
    checkOutput("rst_flags", {a_timeout, a_game_over}, 0);

    // Start, then generator result without draw completion lands in PICK.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("start_gen", a_step, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("gen_pick", a_step, 2);
    checkOutput("gen_player", a_player, 0);
    checkOutput("gen_round", a_round, 0);

    // Idle inputs in PICK: four PICK cycles, one TOUT cycle, then next turn.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("pick_hold", a_step, 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tout_step", a_step, 4);
    checkOutput("tout_flag", a_timeout, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_tout_step", a_step, 1);
    checkOutput("after_tout_flag", a_timeout, 0);
    checkOutput("after_tout_player", a_player, 1);
    checkOutput("after_tout_round", a_round, 1);
    checkOutput("b_no_expiry", b_step, 2);

    // A winning turn for player 0.
    do_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("check_step", a_step, 7);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("win_step", a_step, 8);
    checkOutput("win_score", a_score, 8'h01);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("win_next_step", a_step, 1);
    checkOutput("win_next_player", a_player, 1);

    // Two missed turns end a two-round game.
    do_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 2; t++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
    end
    checkOutput("over_step", a_step, 9);
    checkOutput("over_flag", a_game_over, 1);
    checkOutput("over_player", a_player, 0);
    checkOutput("over_round", a_round, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("over_finish", a_step, 0);
    checkOutput("b_finish_in_gen", b_step, 1);

    // finish ignored in PICK, then reset asynchronously while in CHECK.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("finish_in_pick", a_step, 2);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("pre_reset_check", a_step, 7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_step", a_step, 0);
    checkOutput("async_round", a_round, 0);
    checkOutput("async_player", a_player, 0);
    checkOutput("async_score", a_score, 0);
    checkOutput("async_flags", {a_timeout, a_game_over}, 0);
    checkOutput("async_b_step", b_step, 0);
    start = 0; rand_ready = 0; done = 0; select = 0; win = 0; miss = 0; finish = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-player instance: five wins saturate a 2-bit score.
    do_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 5; t++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("b_sat_score", b_score, sat_tbl[t]);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("b_sat_round", b_round, 5);
    checkOutput("b_sat_player", b_player, 0);
    checkOutput("b_sat_step", b_step, 1);

    // Randomized traffic with periodic resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) do_reset();
      else applyStimulus(pct(30), pct(50), pct(30), pct(40), pct(30), pct(30), pct(5));
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of players in turn rotation (1..4).
REQ-002 SHALL have parameter ROUNDS, default 8, turns per game (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, max cycles in PICK before timeout (0 disables).
REQ-004 SHALL have parameter SCORE_W, default 4, width of each per-player score.
REQ-005 SHALL have ports:
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  start  in  1  begin game (IDLE) / continue after win (WIN)
  rand_ready  in  1  random generator result valid
  done  in  1  board/draw operation complete
  select  in  1  player selection strobe
  win  in  1  selection matched
  miss  in  1  selection did not match
  finish  in  1  abort/end game, return to IDLE
  step  out  4  current state encoding
  player  out  $clog2(PLAYERS) (min 1)  active player index
  round  out  8  completed turns this game
  score  out  PLAYERS*SCORE_W  packed scores, player 0 in LSBs
  timeout  out  1  high for the single TOUT cycle
  game_over  out  1  high while in OVER

Function
REQ-006 SHALL encode states: IDLE=0, GEN=1, PICK=2, SHOW=3, TOUT=4, CHECK=7, WIN=8, OVER=9; step SHALL equal the registered state.
REQ-007 IDLE: start -> GEN, clearing round, player and all scores in the same edge.
REQ-008 GEN: rand_ready&done -> SHOW; rand_ready&!done -> PICK; else hold.
REQ-009 SHOW: select -> PICK; else hold.
REQ-010 PICK priority: select&done -> CHECK; else done -> GEN; else timer expiry -> TOUT; else hold.
REQ-011 Timer SHALL clear on every PICK entry and count cycles spent in PICK; expiry occurs on the cycle count reaches TIMEOUT_CYC-1, so PICK lasts exactly TIMEOUT_CYC cycles with no exit condition.
REQ-012 TIMEOUT_CYC=0 SHALL never assert expiry.
REQ-013 CHECK priority: finish -> IDLE; else win -> WIN; else miss -> turn end; else hold.
REQ-014 WIN entry SHALL increment score[player] by 1, saturating at 2**SCORE_W-1.
REQ-015 WIN: finish -> IDLE; else start -> turn end; else hold.
REQ-016 TOUT SHALL last exactly one cycle, then perform turn end.
REQ-017 Turn end SHALL increment round and advance player modulo PLAYERS (PLAYERS-1 wraps to 0); next state OVER if incremented round equals ROUNDS, else GEN.
REQ-018 OVER: finish -> IDLE; else hold; scores and round held for display.
REQ-019 finish SHALL be ignored in GEN, PICK, SHOW, TOUT (only CHECK, WIN, OVER honour it).
REQ-020 Undefined state encodings SHALL transition to IDLE next cycle.
REQ-021 timeout = (state==TOUT); game_over = (state==OVER); both purely decoded from state, no extra latency.
REQ-022 Leaving IDLE via finish-return SHALL NOT clear scores; clearing occurs only on start in IDLE or reset.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, step=0, player=0, round=0, score=0, timer=0, timeout=0, game_over=0.
REQ-024 Reset mid-game SHALL discard all progress; first edge after release evaluates IDLE.

Structure
REQ-025 State typedef enum (4-bit, encodings per REQ-006) SHALL live in shared package game_pkg, with constant STEP_W=4.
REQ-026 Timeout counter SHALL be sub-module game_timer (inputs clear, enable; output expired; parameter LIMIT).
REQ-027 Next-state logic SHALL be one combinational block; all registers in one asynchronous-reset sequential block.

Verification
REQ-028 Reset then start=1 one cycle, rand_ready=1,done=0 -> step 0->1->2, player=0, round=0.
REQ-029 In PICK, TIMEOUT_CYC=4, hold all inputs 0 -> step=2 for 4 cycles, step=4 with timeout=1 one cycle, then step=1, player=1, round=1.
REQ-030 PICK select&done, CHECK win=1 -> step=8, score[0] 0->1; then start=1 -> step=1, player=1.
REQ-031 PLAYERS=2, ROUNDS=2, two consecutive miss turns -> after second, step=9, game_over=1, player=0, round=2; finish -> step=0.
REQ-032 SCORE_W=2, player 0 wins 5 times -> score[0] saturates at 3.
REQ-033 rst_n asserted while step=7 -> all outputs zero immediately, before next clk edge.
